wav_stream_parser: RTL and testbench

- Sits between the SD read stage (rd_val_en/rd_val_data, sd_clk domain) and the audio FIFO write port.
- Parses the RIFF/WAVE header of a file streamed from SD, latches the format fields and strips the header.
- Forwards only PCM payload words, byte-swapped to little-endian sample order, and flags end of data.
- Removes the need for hard-coded start-sector and length parameters that assume a header-free file.

---
 rtl/wav_pkg.sv | 37 +++
 rtl/wav_stream_parser.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_wav_stream_parser.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wav_pkg.sv
// Shared definitions for the WAV stream parser: FSM state encoding,
// RIFF/WAVE chunk identifiers as they appear in card byte order
// ({first byte, second byte}), the PCM format code and a byte-swap helper.
package wav_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RIFF_ID   = 4'd1,
        ST_RIFF_SIZE = 4'd2,
        ST_WAVE_ID   = 4'd3,
        ST_CK_ID     = 4'd4,
        ST_CK_SIZE   = 4'd5,
        ST_FMT_BODY  = 4'd6,
        ST_SKIP      = 4'd7,
        ST_DATA      = 4'd8,
        ST_DONE      = 4'd9,
        ST_ERR       = 4'd10
    } state_e;

    // Chunk ids, two 16-bit words each, first word arrives first.
    localparam logic [15:0] ID_RIFF0 = 16'h5249;
    localparam logic [15:0] ID_RIFF1 = 16'h4646;
    localparam logic [15:0] ID_WAVE0 = 16'h5741;
    localparam logic [15:0] ID_WAVE1 = 16'h5645;
    localparam logic [15:0] ID_FMT0  = 16'h666D;
    localparam logic [15:0] ID_FMT1  = 16'h7420;
    localparam logic [15:0] ID_DATA0 = 16'h6461;
    localparam logic [15:0] ID_DATA1 = 16'h7461;

    localparam logic [15:0] PCM_FORMAT = 16'h0001;

    // Card order {b0, b1} to little-endian value order {b1, b0}.
    function automatic logic [15:0] swap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/wav_stream_parser.sv
// wav_stream_parser
// Parses the RIFF/WAVE header of a file streamed word-by-word from SD,
// latches the fmt fields, strips the header and forwards only the PCM
// payload (byte-swapped to sample order) to the audio FIFO write port.
//
// Ports:
//   clk, rst_n       sd_clk domain clock, async active-low reset
//   start            1-cycle pulse: abort, clear everything, expect RIFF
//   in_valid/in_data input word strobe and word {first byte, second byte}
//   pcm_valid/data   payload strobe (1 clk after input) and swapped word
//   hdr_done         data chunk reached, format fields valid
//   hdr_err          malformed header (sticky until start/reset)
//   play_done        all payload words forwarded
//   num_channels, sample_rate, bits_per_sample, data_bytes  latched fields
module wav_stream_parser
    import wav_pkg::*;
#(
    parameter int MAX_HDR_WORDS = 2048,
    parameter int DW            = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          pcm_valid,
    output logic [DW-1:0] pcm_data,
    output logic          hdr_done,
    output logic          hdr_err,
    output logic          play_done,
    output logic [15:0]   num_channels,
    output logic [31:0]   sample_rate,
    output logic [15:0]   bits_per_sample,
    output logic [31:0]   data_bytes
);

    localparam logic [31:0] MAX_HDR_L = 32'(MAX_HDR_WORDS);

    state_e      state_q, state_d;
    logic        ph_q, ph_d;           // word phase inside 2-word fields
    logic [15:0] w0_q, w0_d;           // first word of a 2-word field
    logic [15:0] id0_q, id0_d;
    logic [15:0] id1_q, id1_d;
    logic [3:0]  k_q, k_d;             // fmt word index, saturates at 8
    logic [31:0] rem_q, rem_d;         // words left in current chunk
    logic [31:0] hdr_cnt_q, hdr_cnt_d; // words consumed before DATA
    logic        pcm_valid_q, pcm_valid_d;
    logic [15:0] pcm_data_q, pcm_data_d;
    logic        hdr_done_q, hdr_done_d;
    logic        hdr_err_q, hdr_err_d;
    logic        play_done_q, play_done_d;
    logic [15:0] nch_q, nch_d;
    logic [31:0] sr_q, sr_d;
    logic [15:0] bps_q, bps_d;
    logic [31:0] dbytes_q, dbytes_d;

    logic [15:0] word_sw_s;
    logic [31:0] size_s;
    logic [32:0] size_p1_s;
    logic [31:0] rem_init_s;
    logic [31:0] hdr_cnt_inc_s;
    logic        is_fmt_s;
    logic        is_data_s;
    logic        in_hdr_s;
    logic        fmt_bad_s;

    // Field decode helpers shared by several states.
    always_comb begin
        word_sw_s     = swap16(in_data);
        size_s        = {word_sw_s, swap16(w0_q)};
        // 33-bit add so a size of 32'hFFFFFFFF still rounds up correctly.
        size_p1_s     = {1'b0, size_s} + 33'd1;
        rem_init_s    = 32'(size_p1_s >> 1);
        hdr_cnt_inc_s = hdr_cnt_q + 32'd1;
        is_fmt_s      = (id0_q == ID_FMT0) && (id1_q == ID_FMT1);
        is_data_s     = (id0_q == ID_DATA0) && (id1_q == ID_DATA1);
        in_hdr_s      = (state_q >= ST_RIFF_ID) && (state_q <= ST_SKIP);
        fmt_bad_s     = (k_q == 4'd0) && (word_sw_s != PCM_FORMAT);
    end

    // Next-state and datapath updates; acts only on start or in_valid.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        w0_d        = w0_q;
        id0_d       = id0_q;
        id1_d       = id1_q;
        k_d         = k_q;
        rem_d       = rem_q;
        hdr_cnt_d   = hdr_cnt_q;
        pcm_valid_d = 1'b0;
        pcm_data_d  = pcm_data_q;
        nch_d       = nch_q;
        sr_d        = sr_q;
        bps_d       = bps_q;
        dbytes_d    = dbytes_q;

        if (start) begin
            // The word arriving with start is deliberately dropped.
            state_d    = ST_RIFF_ID;
            ph_d       = 1'b0;
            w0_d       = 16'h0000;
            id0_d      = 16'h0000;
            id1_d      = 16'h0000;
            k_d        = 4'd0;
            rem_d      = 32'd0;
            hdr_cnt_d  = 32'd0;
            pcm_data_d = 16'h0000;
            nch_d      = 16'h0000;
            sr_d       = 32'd0;
            bps_d      = 16'h0000;
            dbytes_d   = 32'd0;
        end else if (in_valid) begin
            case (state_q)
                ST_RIFF_ID: begin
                    ph_d = ~ph_q;
                    if (in_data != (ph_q ? ID_RIFF1 : ID_RIFF0)) begin
                        state_d = ST_ERR;
                    end else if (ph_q) begin
                        state_d = ST_RIFF_SIZE;
                    end else begin
                        state_d = ST_RIFF_ID;
                    end
                end
                ST_RIFF_SIZE: begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        state_d = ST_WAVE_ID;
                    end else begin
                        state_d = ST_RIFF_SIZE;
                    end
                end
                ST_WAVE_ID: begin
                    ph_d = ~ph_q;
                    if (in_data != (ph_q ? ID_WAVE1 : ID_WAVE0)) begin
                        state_d = ST_ERR;
                    end else if (ph_q) begin
                        state_d = ST_CK_ID;
                    end else begin
                        state_d = ST_WAVE_ID;
                    end
                end
                ST_CK_ID: begin
                    ph_d = ~ph_q;
                    if (ph_q) begin
                        id0_d   = w0_q;
                        id1_d   = in_data;
                        state_d = ST_CK_SIZE;
                    end else begin
                        w0_d = in_data;
                    end
                end
                ST_CK_SIZE: begin
                    ph_d = ~ph_q;
                    if (!ph_q) begin
                        w0_d = in_data;
                    end else begin
                        rem_d = rem_init_s;
                        k_d   = 4'd0;
                        if (is_fmt_s) begin
                            if (size_s < 32'd16) begin
                                state_d = ST_ERR;
                            end else begin
                                state_d = ST_FMT_BODY;
                            end
                        end else if (is_data_s) begin
                            dbytes_d = size_s;
                            if (rem_init_s == 32'd0) begin
                                state_d = ST_DONE;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else begin
                            if (rem_init_s == 32'd0) begin
                                state_d = ST_CK_ID;
                            end else begin
                                state_d = ST_SKIP;
                            end
                        end
                    end
                end
                ST_FMT_BODY: begin
                    rem_d = rem_q - 32'd1;
                    if (k_q != 4'd8) begin
                        k_d = k_q + 4'd1;
                    end else begin
                        k_d = k_q;
                    end
                    case (k_q)
                        4'd1:    nch_d = word_sw_s;
                        4'd2:    sr_d  = {sr_q[31:16], word_sw_s};
                        4'd3:    sr_d  = {word_sw_s, sr_q[15:0]};
                        4'd7:    bps_d = word_sw_s;
                        default: nch_d = nch_q;
                    endcase
                    if (fmt_bad_s) begin
                        state_d = ST_ERR;
                    end else if (rem_q == 32'd1) begin
                        state_d = ST_CK_ID;
                    end else begin
                        state_d = ST_FMT_BODY;
                    end
                end
                ST_SKIP: begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = ST_CK_ID;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
                ST_DATA: begin
                    pcm_valid_d = 1'b1;
                    pcm_data_d  = word_sw_s;
                    rem_d       = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR ignore input.
                    state_d = state_q;
                end
            endcase

            // Header length guard overrides whatever the chunk logic chose.
            if (in_hdr_s) begin
                hdr_cnt_d = hdr_cnt_inc_s;
                if (hdr_cnt_inc_s > MAX_HDR_L) begin
                    state_d = ST_ERR;
                end else begin
                    hdr_cnt_d = hdr_cnt_inc_s;
                end
            end else begin
                hdr_cnt_d = hdr_cnt_q;
            end
        end else begin
            state_d = state_q;
        end

        hdr_done_d  = (state_d == ST_DATA) || (state_d == ST_DONE);
        hdr_err_d   = (state_d == ST_ERR);
        play_done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ph_q        <= 1'b0;
            w0_q        <= 16'h0000;
            id0_q       <= 16'h0000;
            id1_q       <= 16'h0000;
            k_q         <= 4'd0;
            rem_q       <= 32'd0;
            hdr_cnt_q   <= 32'd0;
            pcm_valid_q <= 1'b0;
            pcm_data_q  <= 16'h0000;
            hdr_done_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
            play_done_q <= 1'b0;
            nch_q       <= 16'h0000;
            sr_q        <= 32'd0;
            bps_q       <= 16'h0000;
            dbytes_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            w0_q        <= w0_d;
            id0_q       <= id0_d;
            id1_q       <= id1_d;
            k_q         <= k_d;
            rem_q       <= rem_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pcm_valid_q <= pcm_valid_d;
            pcm_data_q  <= pcm_data_d;
            hdr_done_q  <= hdr_done_d;
            hdr_err_q   <= hdr_err_d;
            play_done_q <= play_done_d;
            nch_q       <= nch_d;
            sr_q        <= sr_d;
            bps_q       <= bps_d;
            dbytes_q    <= dbytes_d;
        end
    end

    assign pcm_valid       = pcm_valid_q;
    assign pcm_data        = pcm_data_q;
    assign hdr_done        = hdr_done_q;
    assign hdr_err         = hdr_err_q;
    assign play_done       = play_done_q;
    assign num_channels    = nch_q;
    assign sample_rate     = sr_q;
    assign bits_per_sample = bps_q;
    assign data_bytes      = dbytes_q;

endmodule

// File: tb/tb_wav_stream_parser.sv
// Directed, table-driven bench for wav_stream_parser. Each table row is one
// clock: inputs applied, then the flags/payload expected after that edge.
module tb_wav_stream_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;

    logic        pcm_valid, hdr_done, hdr_err, play_done;
    logic [15:0] pcm_data, num_channels, bits_per_sample;
    logic [31:0] sample_rate, data_bytes;

    logic        b_pcm_valid, b_hdr_done, b_hdr_err, b_play_done;
    logic [15:0] b_pcm_data, b_num_channels, b_bits_per_sample;
    logic [31:0] b_sample_rate, b_data_bytes;

    int tests = 0;
    int failed = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic        st;
        logic        iv;
        logic [15:0] d;
        logic        pv;
        logic [15:0] pd;
        logic        hd;
        logic        he;
        logic        pdn;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    wav_stream_parser #(.MAX_HDR_WORDS(2048), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .pcm_valid(pcm_valid), .pcm_data(pcm_data),
        .hdr_done(hdr_done), .hdr_err(hdr_err), .play_done(play_done),
        .num_channels(num_channels), .sample_rate(sample_rate),
        .bits_per_sample(bits_per_sample), .data_bytes(data_bytes)
    );

    wav_stream_parser #(.MAX_HDR_WORDS(32), .DW(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .pcm_valid(b_pcm_valid), .pcm_data(b_pcm_data),
        .hdr_done(b_hdr_done), .hdr_err(b_hdr_err), .play_done(b_play_done),
        .num_channels(b_num_channels), .sample_rate(b_sample_rate),
        .bits_per_sample(b_bits_per_sample), .data_bytes(b_data_bytes)
    );

    function automatic logic [15:0] sw(input logic [15:0] x);
        return {x[7:0], x[15:8]};
    endfunction

    task automatic v(input logic s, input logic iv, input logic [15:0] d,
                     input logic pv, input logic [15:0] pd,
                     input logic hd, input logic he, input logic pdn);
        vec_t t;
        t.st = s; t.iv = iv; t.d = d; t.pv = pv; t.pd = pd;
        t.hd = hd; t.he = he; t.pdn = pdn;
        tbl.push_back(t);
    endtask

    task automatic hrow(input logic [15:0] d);
        v(1'b0, 1'b1, d, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic prow(input logic [15:0] d, input logic last);
        v(1'b0, 1'b1, d, 1'b1, sw(d), 1'b1, 1'b0, last);
    endtask

    task automatic add_hdr(input logic [15:0] ch, input logic [31:0] rate,
                           input logic [15:0] bps, input bit list,
                           input logic [31:0] dsize);
        hrow(16'h5249); hrow(16'h4646); hrow(16'h2C00); hrow(16'h0000);
        hrow(16'h5741); hrow(16'h5645);
        hrow(16'h666D); hrow(16'h7420); hrow(16'h1000); hrow(16'h0000);
        hrow(16'h0100); hrow(sw(ch)); hrow(sw(rate[15:0])); hrow(sw(rate[31:16]));
        hrow(16'h00EE); hrow(16'h0200); hrow(16'h0400); hrow(sw(bps));
        if (list) begin
            hrow(16'h4C49); hrow(16'h5354); hrow(16'h1A00); hrow(16'h0000);
            for (int i = 0; i < 13; i++) hrow(16'h2020);
        end
        hrow(16'h6461); hrow(16'h7461); hrow(sw(dsize[15:0]));
        v(1'b0, 1'b1, sw(dsize[31:16]), 1'b0, 16'h0000, 1'b1, 1'b0,
          (dsize == 32'd0));
    endtask

    task automatic check_row(input vec_t e, input string tag, input int idx);
        logic [18:0] got, exp;
        got = {pcm_valid, pcm_valid ? pcm_data : 16'h0000, hdr_done, play_done};
        exp = {e.pv, e.pv ? e.pd : 16'h0000, e.hd, e.pdn};
        tests++;
        if (pcm_valid) pulse_cnt++;
        if (got !== exp || hdr_err !== e.he) begin
            failed++;
            $display("FAIL %s[%0d]: got pv/pd/hd/pdn=%h err=%b, want %h err=%b",
                     tag, idx, got, hdr_err, exp, e.he);
        end
    endtask

    task automatic run_table(input bit gaps, input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                vec_t g;
                g = tbl[i-1];
                g.pv = 1'b0;
                @(negedge clk);
                @(posedge clk); #1;
                check_row(g, {tag, "_gap"}, i);
            end
            @(negedge clk);
            start = tbl[i].st; in_valid = tbl[i].iv; in_data = tbl[i].d;
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b0;
            check_row(tbl[i], tag, i);
        end
        tbl.delete();
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [15:0] d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic fields(input string tag, input logic [15:0] ch,
                          input logic [31:0] rate, input logic [15:0] bps,
                          input logic [31:0] db);
        chk({tag, "_nch"}, {16'h0000, num_channels}, {16'h0000, ch});
        chk({tag, "_rate"}, sample_rate, rate);
        chk({tag, "_bps"}, {16'h0000, bits_per_sample}, {16'h0000, bps});
        chk({tag, "_dbytes"}, data_bytes, db);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_flags", {27'd0, pcm_valid, hdr_done, hdr_err, play_done, 1'b0}, 32'd0);
        chk("reset_pcm_data", {16'h0000, pcm_data}, 32'd0);
        fields("reset", 16'd0, 32'd0, 16'd0, 32'd0);
        rst_n = 1'b1;

        // IDLE ignores words until a start pulse
        hrow(16'h5249); hrow(16'h4646); hrow(16'h2C00);
        run_table(1'b0, "idle");
        fields("idle", 16'd0, 32'd0, 16'd0, 32'd0);

        // Canonical file: stereo 48 kHz 16-bit, 4 payload words
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_hdr(16'd2, 32'd48000, 16'd16, 1'b0, 32'd8);
        prow(16'h0102, 1'b0); prow(16'h0304, 1'b0);
        prow(16'h0506, 1'b0); prow(16'h0708, 1'b1);
        v(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        v(1'b0, 1'b1, 16'h0A0B, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_table(1'b0, "canon");
        fields("canon", 16'd2, 32'd48000, 16'd16, 32'd8);

        // Same with a LIST chunk to skip
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_hdr(16'd2, 32'd48000, 16'd16, 1'b1, 32'd8);
        prow(16'h0102, 1'b0); prow(16'h0304, 1'b0);
        prow(16'h0506, 1'b0); prow(16'h0708, 1'b1);
        run_table(1'b0, "list");
        fields("list", 16'd2, 32'd48000, 16'd16, 32'd8);

        // Bad RIFF id
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        hrow(16'h5249);
        v(1'b0, 1'b1, 16'h4647, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b1, 16'h5741, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        v(1'b0, 1'b1, 16'h6461, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_table(1'b0, "badriff");

        // Odd data size 5 with random input gaps: 3 words out
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_hdr(16'd1, 32'd8000, 16'd8, 1'b0, 32'd5);
        prow(16'h1122, 1'b0); prow(16'h3344, 1'b0); prow(16'h5500, 1'b1);
        v(1'b0, 1'b1, 16'h6677, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        pulse_cnt = 0;
        run_table(1'b1, "odd");
        chk("odd_pulses", 32'(pulse_cnt), 32'd3);
        chk("odd_dbytes", data_bytes, 32'd5);

        // start mid-payload, coincident with a valid word
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_hdr(16'd2, 32'd48000, 16'd16, 1'b0, 32'd8);
        prow(16'h0102, 1'b0); prow(16'h0304, 1'b0);
        v(1'b1, 1'b1, 16'h5249, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_table(1'b0, "abort");
        fields("abort", 16'd0, 32'd0, 16'd0, 32'd0);
        add_hdr(16'd1, 32'd44100, 16'd24, 1'b0, 32'd4);
        prow(16'hA1B2, 1'b0); prow(16'hC3D4, 1'b1);
        run_table(1'b0, "restart");
        fields("restart", 16'd1, 32'd44100, 16'd24, 32'd4);

        // fmt chunk shorter than 16 bytes
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        hrow(16'h5249); hrow(16'h4646); hrow(16'h2C00); hrow(16'h0000);
        hrow(16'h5741); hrow(16'h5645); hrow(16'h666D); hrow(16'h7420);
        hrow(16'h0E00);
        v(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_table(1'b0, "fmtshort");

        // Empty data chunk goes straight to DONE
        v(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        add_hdr(16'd2, 32'd48000, 16'd16, 1'b0, 32'd0);
        v(1'b0, 1'b1, 16'h0102, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_table(1'b0, "empty");

        // Header length limit on the MAX_HDR_WORDS=32 instance
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        feed(16'h5249); feed(16'h4646); feed(16'h2C00); feed(16'h0000);
        feed(16'h5741); feed(16'h5645); feed(16'h4A55); feed(16'h4E4B);
        feed(16'h4000); feed(16'h0000);
        for (int i = 0; i < 22; i++) feed(16'h0000);
        chk("max_word32_err", {31'd0, b_hdr_err}, 32'd0);
        feed(16'h0000);
        chk("max_word33_err", {31'd0, b_hdr_err}, 32'd1);
        chk("max_word33_done", {31'd0, b_hdr_done}, 32'd0);
        chk("big_limit_no_err", {31'd0, hdr_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
